mastermind_engine: RTL
======================

Name: mastermind_engine

Overview:
Parametrised game core for the FPGA Mastermind/Wordle design. It latches a secret code of PEGS slots, each COLOR_W bits wide, and edits a guess slot by slot under a cursor. It scores each submitted guess as exact and colour-only matches, keeps a per-guess history for the VGA renderer, and ends as win or lose after at most MAX_GUESSES guesses. It sits between the debounced single-pulse button layer and the display logic.

Parameters:
PEGS, 4, number of code slots (>=2).
COLOR_W, 3, bits per slot; colour 0 = empty, legal colours 1..2^COLOR_W-1.
MAX_GUESSES, 8, guesses allowed before loss (>=1).
Derived: CW = clog2(PEGS+1); GW = clog2(MAX_GUESSES+1); PW = clog2(PEGS).

Ports:
Clk  in  1  system clock; all logic on rising edge.
Reset  in  1  synchronous, active-low reset.
start  in  1  single-cycle pulse; begins a game.
answer  in  PEGS*COLOR_W  secret code; slot i at bits [i*COLOR_W +: COLOR_W].
color  in  COLOR_W  colour to write.
confirm_color  in  1  pulse; write color at cursor.
left  in  1  pulse; cursor -1.
right  in  1  pulse; cursor +1.
check_guess  in  1  pulse; submit guess.
ack  in  1  pulse; leave DONE state.
hist_idx  in  GW  history read index.
hist_guess  out  PEGS*COLOR_W  stored guess at hist_idx (combinational read).
hist_exact  out  CW  stored exact count at hist_idx.
hist_partial  out  CW  stored partial count at hist_idx.
current_guess  out  PEGS*COLOR_W  guess being edited.
cursor  out  PW  selected slot.
guess_num  out  GW  guesses scored so far.
exact  out  CW  last exact count.
partial  out  CW  last colour-only count.
score_valid  out  1  one-cycle pulse when exact/partial update.
q_Start, q_Input, q_Score, q_DoneC, q_DoneNC  out  1 each  one-hot state flags.

Behaviour:
- Reset low at a clock edge: state START. All registers zero: answer_reg, current_guess, cursor, guess_num, exact, partial, score_valid, history. Reset mid-game, including in SCORE, aborts with no history write.
- START: start latches answer only if every slot is non-zero. It then clears current_guess, cursor, guess_num, exact, partial and all history, and enters INPUT. start with any zero slot is ignored. All other inputs are ignored in START.
- INPUT: at most one action per cycle, priority check_guess > confirm_color > right > left.
  - confirm_color writes color to slot[cursor]; writing 0 is legal and clears the slot. The cursor then advances by 1 only if cursor < PEGS-1; it does not wrap.
  - right increments the cursor and wraps PEGS-1 -> 0.
  - left decrements the cursor and wraps 0 -> PEGS-1.
  - check_guess with all slots non-zero enters SCORE. With any zero slot it is ignored and the state stays INPUT.
- SCORE: lasts exactly 2^COLOR_W - 1 cycles.
  - On entry, exact_acc = count of i where guess[i] == answer[i].
  - Colour counter c steps 1..2^COLOR_W-1, one per cycle: total_acc += min(count of c in guess, count of c in answer).
  - On the last cycle, for the next edge:
    - exact <= exact_acc; partial <= total_acc - exact_acc.
    - history[guess_num] <= {guess, exact, partial}; guess_num += 1.
    - score_valid = 1 for that one cycle only.
  - Next state: DONE_C if exact_acc == PEGS; else DONE_NC if guess_num+1 == MAX_GUESSES; else INPUT with current_guess and cursor cleared.
  - All button inputs are ignored in SCORE.
- DONE_C / DONE_NC: all outputs hold. ack returns to START; history and guess_num remain readable until the next accepted start.
- History read: hist_idx >= guess_num returns zeros. hist_idx >= MAX_GUESSES returns zeros.
- Counts never exceed PEGS. partial never underflows, because total_acc >= exact_acc by construction.

Test Plan:
(PEGS=4, COLOR_W=3, MAX_GUESSES=8; codes listed slot0..slot3.)
- Reset: hold Reset=0 two cycles -> q_Start=1, all other outputs 0. start with answer 1,2,0,4 -> stays in START.
- Win: answer 1,2,3,4; enter 1,2,3,4; check -> q_Score for 7 cycles, score_valid pulse, exact=4, partial=0, guess_num=1, q_DoneC=1.
- Scoring: answer 1,1,2,3; guess 1,2,1,4 -> exact=1, partial=2. Then hist_idx=0 returns guess 1,2,1,4, exact 1, partial 2.
- Editing: cursor=0, left -> cursor=3. confirm_color at cursor 3 -> cursor stays 3. Guess 5,0,5,5 plus check -> ignored, q_Input=1. check and right in the same cycle -> check wins.
- Loss: 8 non-winning guesses -> q_DoneNC=1 after the 8th score_valid, guess_num=8, hist_idx=7 returns the 8th guess. ack -> q_Start=1.
- Abort: Reset=0 during the 4th SCORE cycle -> START, guess_num=0, no history entry written.

Source files
------------

// File: rtl/mastermind_engine.sv
// Mastermind game core: latches a secret code, edits a guess under a cursor, scores guesses
// colour by colour and keeps a per-guess history for the display.
module mastermind_engine #(
    parameter int unsigned PEGS        = 4,
    parameter int unsigned COLOR_W     = 3,
    parameter int unsigned MAX_GUESSES = 8,
    localparam int unsigned CW     = $clog2(PEGS + 1),
    localparam int unsigned GW     = $clog2(MAX_GUESSES + 1),
    localparam int unsigned PW     = $clog2(PEGS),
    localparam int unsigned CODE_W = PEGS * COLOR_W
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_start,
    input  logic [CODE_W-1:0] i_answer,
    input  logic [COLOR_W-1:0] i_color,
    input  logic              i_confirm_color,
    input  logic              i_left,
    input  logic              i_right,
    input  logic              i_check_guess,
    input  logic              i_ack,
    input  logic [GW-1:0]     i_hist_idx,
    output logic [CODE_W-1:0] o_hist_guess,
    output logic [CW-1:0]     o_hist_exact,
    output logic [CW-1:0]     o_hist_partial,
    output logic [CODE_W-1:0] o_current_guess,
    output logic [PW-1:0]     o_cursor,
    output logic [GW-1:0]     o_guess_num,
    output logic [CW-1:0]     o_exact,
    output logic [CW-1:0]     o_partial,
    output logic              o_score_valid,
    output logic              o_q_start,
    output logic              o_q_input,
    output logic              o_q_score,
    output logic              o_q_done_c,
    output logic              o_q_done_nc
);

    localparam int unsigned HW   = (MAX_GUESSES > 1) ? $clog2(MAX_GUESSES) : 1;
    localparam int unsigned NCOL = (1 << COLOR_W) - 1;

    typedef enum logic [2:0] {StStart, StInput, StScore, StDoneC, StDoneNc} state_e;

    state_e             r_state, w_state_next;
    logic [CODE_W-1:0]  r_answer, r_guess, w_guess_written;
    logic [PW-1:0]      r_cursor;
    logic [GW-1:0]      r_guess_num;
    logic [CW-1:0]      r_exact, r_partial, r_total;
    logic               r_score_valid;
    logic [COLOR_W-1:0] r_color;
    logic [CODE_W-1:0]  r_hist_guess   [MAX_GUESSES];
    logic [CW-1:0]      r_hist_exact   [MAX_GUESSES];
    logic [CW-1:0]      r_hist_partial [MAX_GUESSES];

    logic              w_answer_ok, w_guess_full, w_last, w_win, w_final, w_hist_hit;
    logic [CW-1:0]     w_exact, w_cnt_g, w_cnt_a, w_min, w_total_next;
    logic [HW-1:0]     w_hist_sel, w_hist_wr;

    function automatic logic [CW-1:0] count_color(input logic [CODE_W-1:0] code,
                                                  input logic [COLOR_W-1:0] c);
        logic [CW-1:0] n;
        n = '0;
        for (int i = 0; i < PEGS; i++) begin
            if (code[i*COLOR_W +: COLOR_W] == c) n = n + CW'(1);
        end
        return n;
    endfunction

    always_comb begin
        w_answer_ok     = 1'b1;
        w_guess_full    = 1'b1;
        w_exact         = '0;
        w_guess_written = r_guess;
        for (int i = 0; i < PEGS; i++) begin
            if (i_answer[i*COLOR_W +: COLOR_W] == '0) w_answer_ok = 1'b0;
            if (r_guess[i*COLOR_W +: COLOR_W] == '0) w_guess_full = 1'b0;
            if (r_guess[i*COLOR_W +: COLOR_W] == r_answer[i*COLOR_W +: COLOR_W]) begin
                w_exact = w_exact + CW'(1);
            end
            if (r_cursor == PW'(i)) w_guess_written[i*COLOR_W +: COLOR_W] = i_color;
        end
    end

    // One colour per SCORE cycle; the running total includes the colour under test.
    assign w_cnt_g      = count_color(r_guess, r_color);
    assign w_cnt_a      = count_color(r_answer, r_color);
    assign w_min        = (w_cnt_g < w_cnt_a) ? w_cnt_g : w_cnt_a;
    assign w_total_next = r_total + w_min;
    assign w_last       = (r_color == COLOR_W'(NCOL));
    assign w_win        = (w_exact == CW'(PEGS));
    assign w_final      = (r_guess_num == GW'(MAX_GUESSES - 1));
    assign w_hist_wr    = r_guess_num[HW-1:0];

    always_ff @(posedge i_clk) begin
        if (!i_reset) r_state <= StStart;
        else          r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        o_q_start    = 1'b0;
        o_q_input    = 1'b0;
        o_q_score    = 1'b0;
        o_q_done_c   = 1'b0;
        o_q_done_nc  = 1'b0;
        unique case (r_state)
            StStart: begin
                o_q_start = 1'b1;
                if (i_start && w_answer_ok) w_state_next = StInput;
            end
            StInput: begin
                o_q_input = 1'b1;
                if (i_check_guess && w_guess_full) w_state_next = StScore;
            end
            StScore: begin
                o_q_score = 1'b1;
                if (w_last) begin
                    if (w_win)        w_state_next = StDoneC;
                    else if (w_final) w_state_next = StDoneNc;
                    else              w_state_next = StInput;
                end
            end
            StDoneC: begin
                o_q_done_c = 1'b1;
                if (i_ack) w_state_next = StStart;
            end
            StDoneNc: begin
                o_q_done_nc = 1'b1;
                if (i_ack) w_state_next = StStart;
            end
            default: w_state_next = StStart;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_answer      <= '0;
            r_guess       <= '0;
            r_cursor      <= '0;
            r_guess_num   <= '0;
            r_exact       <= '0;
            r_partial     <= '0;
            r_total       <= '0;
            r_score_valid <= 1'b0;
            r_color       <= '0;
            for (int i = 0; i < MAX_GUESSES; i++) begin
                r_hist_guess[i]   <= '0;
                r_hist_exact[i]   <= '0;
                r_hist_partial[i] <= '0;
            end
        end else begin
            r_score_valid <= 1'b0;
            case (r_state)
                StStart: begin
                    if (i_start && w_answer_ok) begin
                        r_answer    <= i_answer;
                        r_guess     <= '0;
                        r_cursor    <= '0;
                        r_guess_num <= '0;
                        r_exact     <= '0;
                        r_partial   <= '0;
                        for (int i = 0; i < MAX_GUESSES; i++) begin
                            r_hist_guess[i]   <= '0;
                            r_hist_exact[i]   <= '0;
                            r_hist_partial[i] <= '0;
                        end
                    end
                end
                StInput: begin
                    // A rejected check still consumes the cycle's single action.
                    if (i_check_guess) begin
                        if (w_guess_full) begin
                            r_color <= COLOR_W'(1);
                            r_total <= '0;
                        end
                    end else if (i_confirm_color) begin
                        r_guess <= w_guess_written;
                        if (r_cursor != PW'(PEGS - 1)) r_cursor <= r_cursor + PW'(1);
                    end else if (i_right) begin
                        r_cursor <= (r_cursor == PW'(PEGS - 1)) ? '0 : r_cursor + PW'(1);
                    end else if (i_left) begin
                        r_cursor <= (r_cursor == '0) ? PW'(PEGS - 1) : r_cursor - PW'(1);
                    end
                end
                StScore: begin
                    r_color <= r_color + COLOR_W'(1);
                    r_total <= w_total_next;
                    if (w_last) begin
                        r_exact                   <= w_exact;
                        r_partial                 <= w_total_next - w_exact;
                        r_hist_guess[w_hist_wr]   <= r_guess;
                        r_hist_exact[w_hist_wr]   <= w_exact;
                        r_hist_partial[w_hist_wr] <= w_total_next - w_exact;
                        r_guess_num               <= r_guess_num + GW'(1);
                        r_score_valid             <= 1'b1;
                        if (!w_win && !w_final) begin
                            r_guess  <= '0;
                            r_cursor <= '0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign w_hist_sel = i_hist_idx[HW-1:0];
    assign w_hist_hit = (i_hist_idx < r_guess_num) && (i_hist_idx < GW'(MAX_GUESSES));

    assign o_hist_guess    = w_hist_hit ? r_hist_guess[w_hist_sel]   : '0;
    assign o_hist_exact    = w_hist_hit ? r_hist_exact[w_hist_sel]   : '0;
    assign o_hist_partial  = w_hist_hit ? r_hist_partial[w_hist_sel] : '0;
    assign o_current_guess = r_guess;
    assign o_cursor        = r_cursor;
    assign o_guess_num     = r_guess_num;
    assign o_exact         = r_exact;
    assign o_partial       = r_partial;
    assign o_score_valid   = r_score_valid;

endmodule
